// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - bit-serial subtractor, one difference bit per clock, LSB first
module sub_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_d;
   logic             r_bo;
   logic             r_ovf;
   logic             r_zero;
   logic             w_bit;
   logic             w_br_next;
   logic             w_last;
   logic [WIDTH-1:0] w_diff;

   // Operands shift right so bit 0 is always the bit being resolved; on the
   // last step bit 0 holds the original MSBs used for overflow.
   assign w_bit     = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   assign w_diff    = {w_bit, r_acc[WIDTH-1:1]};
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_br   <= 1'b0;
         r_cnt  <= '0;
         r_d    <= '0;
         r_bo   <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         r_a   <= a;
         r_b   <= b;
         r_br  <= bi;
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_br  <= w_br_next;
         r_acc <= w_diff;
         r_cnt <= r_cnt + 1'b1;
         // Visible results change only here, when the final bit resolves.
         if (w_last) begin
            r_d    <= w_diff;
            r_bo   <= w_br_next;
            r_ovf  <= (r_a[0] ^ r_b[0]) & (w_bit ^ r_a[0]);
            r_zero <= (w_diff == '0);
         end
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);
   assign d    = r_d;
   assign bo   = r_bo;
   assign ovf  = r_ovf;
   assign zero = r_zero;

endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - randomized self-checking bench for sub_serial against an arithmetic model
module tb_sub_serial;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bi;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bo;
   logic         ovf;
   logic         zero;

   int n_checks = 0;
   int n_pass   = 0;

   sub_serial #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bi(bi),
      .busy(busy), .done(done), .d(d), .bo(bo), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic void model(input int ta, input int tb, input int tbi,
                                 output logic [W-1:0] md, output logic mbo,
                                 output logic movf, output logic mzero);
      int diff, sa, sb, sd;
      diff  = ta - tb - tbi;
      sa    = (ta >= (1 << (W - 1))) ? ta - (1 << W) : ta;
      sb    = (tb >= (1 << (W - 1))) ? tb - (1 << W) : tb;
      sd    = sa - sb - tbi;
      md    = W'(diff & ((1 << W) - 1));
      mbo   = (diff < 0);
      movf  = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
      mzero = (md == '0);
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi);
      logic [W-1:0] md, prev_d;
      logic         mbo, movf, mzero;
      int           n;
      model(int'(ta), int'(tb), int'(tbi), md, mbo, movf, mzero);
      prev_d = d;
      a = ta; b = tb; bi = tbi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_run", busy, 1);
      check("d_hold", d, prev_d);
      a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      n = 1;
      while (!done && n < 4 * W) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, W + 1);
      check("d", d, md);
      check("bo", bo, mbo);
      check("ovf", ovf, movf);
      check("zero", zero, mzero);
      check("busy_done", busy, 1);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      int nd, next_exp, seen;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_d", d, 0);
      check("rst_bo", bo, 0);
      check("rst_ovf", ovf, 0);
      check("rst_zero", zero, 0);
      start = 1'b1;
      @(negedge clk);
      check("rst_start_ignored", busy, 0);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);

      do_op(4'd5, 4'd3, 1'b0);
      do_op(4'd3, 4'd5, 1'b0);
      do_op(4'd0, 4'd0, 1'b1);
      do_op(4'd7, 4'd7, 1'b0);
      do_op(4'd8, 4'd1, 1'b0);
      do_op(4'd7, 4'hF, 1'b0);
      do_op(4'hF, 4'hF, 1'b1);
      do_op(4'd8, 4'd0, 1'b1);
      repeat (24) do_op(W'($urandom), W'($urandom), 1'($urandom));

      // start held high continuously: one result every W+2 cycles.
      start = 1'b1; nd = 0; next_exp = W + 1;
      for (int k = 0; k < 5 * (W + 2); k++) begin
         if (!busy) begin a = 4'd9; b = 4'd2; bi = 1'b0; end
         else begin a = W'($urandom); b = W'($urandom); bi = 1'($urandom); end
         @(negedge clk);
         if (done) begin
            check("held_done_time", k + 1, next_exp);
            check("held_d", d, 7);
            nd++;
            next_exp += W + 2;
         end
      end
      start = 1'b0;
      check("held_done_count", nd, 5);

      // Abort two cycles into RUN.
      a = 4'd4; b = 4'd1; bi = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1; start = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_d", d, 0);
      check("abort_bo", bo, 0);
      check("abort_ovf", ovf, 0);
      check("abort_zero", zero, 0);
      seen = 0;
      repeat (W + 2) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check("abort_quiet", seen, 0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("resume_idle", busy, 0);
      do_op(4'd1, 4'd1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
